// File: rtl/riscv_fetch_pkg.sv
// Shared types and defaults for the dual-issue fetch scheduler and its queue.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    FULL     = 2'd1,
    REDIRECT = 2'd2
  } fsm_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr1;
    logic [31:0] instr2;
  } q_entry_t;

  localparam int PC_STEP_DEF = 8;
  localparam int QDEPTH_DEF  = 4;

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of fetched instruction pairs with flush; head is zero when empty.
module fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = QDEPTH_DEF,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           push,
  input  q_entry_t       push_data,
  input  logic           pop,
  output logic [CW-1:0]  count,
  output q_entry_t       head
);

  q_entry_t        storage [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  // Flush wins over any same-edge push or pop.
  assign do_pop  = pop && (count != '0) && !flush;
  assign do_push = push && !flush && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) storage[wr_ptr] <= push_data;
  end

  assign head = (count != '0) ? storage[rd_ptr] : '0;

endmodule

// File: rtl/fetch_sched.sv
// Fetch scheduler: drives pc/pc4 to memory, queues fetched pairs, handles redirects.
module fetch_sched
  import riscv_fetch_pkg::*;
#(
  parameter int QDEPTH  = QDEPTH_DEF,
  parameter int PC_STEP = PC_STEP_DEF,
  localparam int CW = $clog2(QDEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          branch_en,
  input  logic [63:0]   branch_pc,
  output logic [63:0]   pc,
  output logic [63:0]   pc4,
  input  logic [31:0]   instr1_in,
  input  logic [31:0]   instr2_in,
  output logic          issue_valid,
  input  logic          issue_ready,
  output logic [63:0]   issue_pc,
  output logic [31:0]   issue_instr1,
  output logic [31:0]   issue_instr2,
  output logic [CW-1:0] q_count,
  output fsm_state_t    state
);

  fsm_state_t state_next;
  logic       push;
  logic       pop;
  q_entry_t   head;
  q_entry_t   push_data;

  // Issue handshake: the head pair transfers on any edge with issue_valid && issue_ready;
  // issue_valid never waits on issue_ready, and a redirect on that edge cancels the transfer.
  assign issue_valid  = (q_count != '0);
  assign pop          = issue_valid && issue_ready && !branch_en;
  assign push         = (state == FETCH) && !branch_en;
  assign push_data    = '{pc: pc, instr1: instr1_in, instr2: instr2_in};
  assign issue_pc     = head.pc;
  assign issue_instr1 = head.instr1;
  assign issue_instr2 = head.instr2;
  assign pc4          = pc + 64'd4;

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (branch_en),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (q_count),
    .head      (head)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= '0;
    end else begin
      state <= state_next;
      if (branch_en)  pc <= {branch_pc[63:2], 2'b00};
      else if (push)  pc <= pc + 64'(PC_STEP);
    end
  end

  always_comb begin
    state_next = state;
    if (branch_en) begin
      state_next = REDIRECT;
    end else begin
      case (state)
        FETCH:    if (!pop && (q_count == CW'(QDEPTH - 1))) state_next = FULL;
        FULL:     if (pop) state_next = FETCH;
        REDIRECT: state_next = FETCH;
        default:  state_next = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sched.sv
// Directed bench for fetch_sched with a combinational instruction memory model.
module tb_fetch_sched;
  import riscv_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_en;
  logic [63:0] branch_pc;
  logic [63:0] pc;
  logic [63:0] pc4;
  logic [31:0] instr1_in;
  logic [31:0] instr2_in;
  logic        issue_valid;
  logic        issue_ready;
  logic [63:0] issue_pc;
  logic [31:0] issue_instr1;
  logic [31:0] issue_instr2;
  logic [2:0]  q_count;
  fsm_state_t  state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .branch_en    (branch_en),
    .branch_pc    (branch_pc),
    .pc           (pc),
    .pc4          (pc4),
    .instr1_in    (instr1_in),
    .instr2_in    (instr2_in),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_pc     (issue_pc),
    .issue_instr1 (issue_instr1),
    .issue_instr2 (issue_instr2),
    .q_count      (q_count),
    .state        (state)
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'd0) return 32'h015A04B3;
    if (a == 64'd4) return 32'h00148493;
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  always_comb begin
    instr1_in = mem_word(pc);
    instr2_in = mem_word(pc4);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; branch_en = 1'b0; branch_pc = '0; issue_ready = 1'b1;
    step(); step();
    chk("rst_pc",     pc, 64'd0);
    chk("rst_pc4",    pc4, 64'd4);
    chk("rst_count",  64'(q_count), 64'd0);
    chk("rst_valid",  64'(issue_valid), 64'd0);
    chk("rst_ipc",    issue_pc, 64'd0);
    chk("rst_instr1", 64'(issue_instr1), 64'd0);
    chk("rst_state",  64'(state), 64'(FETCH));

    // First push on first released edge
    rst_n = 1'b1;
    step();
    chk("f1_valid",  64'(issue_valid), 64'd1);
    chk("f1_ipc",    issue_pc, 64'd0);
    chk("f1_instr1", 64'(issue_instr1), 64'h015A04B3);
    chk("f1_instr2", 64'(issue_instr2), 64'h00148493);
    chk("f1_pc",     pc, 64'd8);
    step();
    chk("f2_count",  64'(q_count), 64'd1);
    chk("f2_ipc",    issue_pc, 64'd8);
    chk("f2_instr1", 64'(issue_instr1), 64'(mem_word(64'd8)));
    chk("f2_pc",     pc, 64'd16);

    // Fill to FULL with decode stalled
    rst_n = 1'b0; issue_ready = 1'b0;
    step();
    chk("r2_count", 64'(q_count), 64'd0);
    rst_n = 1'b1;
    step(); step(); step();
    chk("fill3_count", 64'(q_count), 64'd3);
    chk("fill3_state", 64'(state), 64'(FETCH));
    step();
    chk("full_count", 64'(q_count), 64'd4);
    chk("full_state", 64'(state), 64'(FULL));
    chk("full_pc",    pc, 64'd32);
    step();
    chk("hold_pc",    pc, 64'd32);
    chk("hold_count", 64'(q_count), 64'd4);
    chk("hold_ipc",   issue_pc, 64'd0);
    issue_ready = 1'b1;
    step();
    chk("pop_count", 64'(q_count), 64'd3);
    chk("pop_state", 64'(state), 64'(FETCH));
    chk("pop_pc",    pc, 64'd32);
    chk("pop_ipc",   issue_pc, 64'd8);
    issue_ready = 1'b0;
    step();
    chk("resume_pc",    pc, 64'd40);
    chk("resume_count", 64'(q_count), 64'd4);
    chk("resume_state", 64'(state), 64'(FULL));

    // Reset while FULL, with a redirect request that must be ignored
    rst_n = 1'b0; branch_en = 1'b1; branch_pc = 64'h1000;
    step();
    chk("rf_pc",    pc, 64'd0);
    chk("rf_count", 64'(q_count), 64'd0);
    chk("rf_valid", 64'(issue_valid), 64'd0);
    chk("rf_ipc",   issue_pc, 64'd0);
    chk("rf_state", 64'(state), 64'(FETCH));
    rst_n = 1'b1; branch_en = 1'b0;
    step();
    chk("rf1_ipc",   issue_pc, 64'd0);
    chk("rf1_count", 64'(q_count), 64'd1);
    chk("rf1_pc",    pc, 64'd8);

    // Redirect while holding 3 entries, then bubble, then push
    step(); step();
    chk("pre_br_count", 64'(q_count), 64'd3);
    branch_en = 1'b1; branch_pc = 64'h56;
    step();
    chk("br_count", 64'(q_count), 64'd0);
    chk("br_pc",    pc, 64'h54);
    chk("br_pc4",   pc4, 64'h58);
    chk("br_state", 64'(state), 64'(REDIRECT));
    chk("br_valid", 64'(issue_valid), 64'd0);
    branch_en = 1'b0;
    step();
    chk("bub_count", 64'(q_count), 64'd0);
    chk("bub_state", 64'(state), 64'(FETCH));
    chk("bub_pc",    pc, 64'h54);
    step();
    chk("bp_valid",  64'(issue_valid), 64'd1);
    chk("bp_ipc",    issue_pc, 64'h54);
    chk("bp_instr1", 64'(issue_instr1), 64'(mem_word(64'h54)));
    chk("bp_instr2", 64'(issue_instr2), 64'(mem_word(64'h58)));
    chk("bp_pc",     pc, 64'h5C);

    // Back-to-back redirects restart the bubble
    branch_en = 1'b1; branch_pc = 64'h100;
    step();
    chk("rr1_pc", pc, 64'h100);
    branch_pc = 64'h203;
    step();
    chk("rr2_pc",    pc, 64'h200);
    chk("rr2_state", 64'(state), 64'(REDIRECT));
    branch_en = 1'b0;
    step();
    chk("rr_bub_count", 64'(q_count), 64'd0);
    step();
    chk("rr_ipc",   issue_pc, 64'h200);
    chk("rr_count", 64'(q_count), 64'd1);

    // Redirect beats a same-edge pop and push
    issue_ready = 1'b1; branch_en = 1'b1; branch_pc = 64'h40;
    step();
    chk("bo_count",  64'(q_count), 64'd0);
    chk("bo_pc",     pc, 64'h40);
    chk("bo_valid",  64'(issue_valid), 64'd0);
    chk("bo_instr1", 64'(issue_instr1), 64'd0);

    // PC wrap-around at the top of the address space
    branch_pc = 64'hFFFF_FFFF_FFFF_FFFB;
    step();
    chk("wr_pc",  pc, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("wr_pc4", pc4, 64'hFFFF_FFFF_FFFF_FFFC);
    branch_en = 1'b0;
    step(); step();
    chk("wr2_pc",    pc, 64'd0);
    chk("wr2_pc4",   pc4, 64'd4);
    chk("wr2_ipc",   issue_pc, 64'hFFFF_FFFF_FFFF_FFF8);
    chk("wr2_count", 64'(q_count), 64'd1);
    step();
    chk("wr3_ipc",    issue_pc, 64'd0);
    chk("wr3_instr1", 64'(issue_instr1), 64'h015A04B3);
    chk("wr3_count",  64'(q_count), 64'd1);
    chk("wr3_pc",     pc, 64'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_sched.md
FETCH_SCHED -- requirements
Module: fetch_sched

Interface
REQ-001 The block SHALL use parameter QDEPTH, default 4, as the fetch-queue depth in instruction pairs (power of two, minimum 2).
REQ-002 The block SHALL use parameter PC_STEP, default 8, as the PC increment per fetched pair.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 branch_en  input  1  redirect request from execute.
REQ-006 branch_pc  input  64  redirect target.
REQ-007 pc  output  64  slot-0 fetch address to instruction memory.
REQ-008 pc4  output  64  slot-1 fetch address, always pc+4.
REQ-009 instr1_in  input  32  memory data at pc, valid combinationally in the same cycle.
REQ-010 instr2_in  input  32  memory data at pc4, valid combinationally in the same cycle.
REQ-011 issue_valid  output  1  queue head holds a valid pair.
REQ-012 issue_ready  input  1  decode accepts the head.
REQ-013 issue_pc  output  64  PC of the head slot-0 instruction.
REQ-014 issue_instr1  output  32  head slot-0 instruction.
REQ-015 issue_instr2  output  32  head slot-1 instruction.
REQ-016 q_count  output  $clog2(QDEPTH)+1  queue occupancy.

Function
REQ-017 The FSM SHALL have three states: FETCH, FULL and REDIRECT.
REQ-018 In FETCH with no branch_en, each edge SHALL push {pc, instr1_in, instr2_in} and set pc <= pc+PC_STEP, with 64-bit wrap-around.
REQ-019 A pop SHALL occur on an edge where issue_valid && issue_ready.
REQ-020 A pop and a push on the same edge SHALL leave q_count unchanged.
REQ-021 When a push would make q_count == QDEPTH, the FSM SHALL go to FULL.
REQ-022 In FULL, pc SHALL hold, no push SHALL occur, and a pop SHALL return the FSM to FETCH.
REQ-023 A push SHALL resume in the cycle after a pop from FULL.
REQ-024 branch_en=1 in any state SHALL override all other actions on that edge:
- the queue is flushed (q_count <= 0) and any same-edge pop or push is discarded;
- pc <= {branch_pc[63:2], 2'b00};
- the FSM goes to REDIRECT.
REQ-025 REDIRECT SHALL last exactly one cycle with no push (memory settle bubble), then go to FETCH; branch_en during REDIRECT SHALL restart REDIRECT with the new target.
REQ-026 Redirect-to-issue latency SHALL be 3 edges: redirect edge, bubble edge, push edge; issue_valid is high after the third edge.
REQ-027 issue_valid SHALL equal (q_count != 0).
REQ-028 issue_* outputs SHALL present the head entry combinationally from queue storage.
REQ-029 issue_* outputs SHALL be zero when the queue is empty.
REQ-030 pc4 SHALL always equal pc+4, modulo 2^64.

Reset
REQ-031 On an edge with rst_n=0, the block SHALL set pc=0, pc4=4, q_count=0, issue_valid=0, issue_* =0 and the FSM to FETCH; branch_en SHALL be ignored.
REQ-032 Reset asserted mid-operation (FULL or REDIRECT) SHALL discard all queued entries in that cycle.
REQ-033 The first push SHALL occur on the first edge with rst_n=1.

Structure
REQ-034 Package riscv_fetch_pkg SHALL hold:
- the FSM state enum;
- the queue-entry struct {pc[63:0], instr1[31:0], instr2[31:0]};
- the PC_STEP and QDEPTH defaults.
REQ-035 Queue storage and pointers SHALL be one sub-module, fetch_queue: circular buffer with push, pop and flush inputs and count/head outputs; the FSM and PC logic SHALL stay in fetch_sched.

Verification
REQ-036 Reset release, issue_ready=1, memory model returning 0x015A04B3/0x00148493 at 0/4 -> after first edge: issue_valid=1, issue_pc=0, issue_instr1=0x015A04B3; pc sequence 0, 8, 16.
REQ-037 issue_ready=0 from reset -> q_count reaches 4 after 4 edges, FSM FULL, pc holds at 32; one pop -> next edge pushes pc=32, pc becomes 40.
REQ-038 branch_en=1, branch_pc=0x56 while queue holds 3 -> q_count=0, pc=0x54 next cycle; bubble; issue_pc=0x54 after the third edge.
REQ-039 branch_en together with issue_ready=1 and a non-full queue -> no pop and no push counted; q_count=0.
REQ-040 rst_n=0 for one cycle while FULL -> pc=0, q_count=0, issue_valid=0; normal fetch from 0 resumes.
REQ-041 pc=0xFFFFFFFFFFFFFFF8 via redirect -> after the push, pc wraps to 0 and pc4 = 4.
